// File: rtl/oai31_bist_pkg.sv
// Shared types and constants for the oai31 self-test driver/checker.
// Holds the FSM encoding, the vector count and the cell's reference function.
package oai31_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, SAMPLE, FIN} state_t;

    localparam int         NUM_VEC    = 16;
    localparam logic [7:0] ARC_EXPECT = 8'hFE;

    // Golden oai31 response for A-code k = {A1,A2,A3} and input B.
    function automatic logic exp_zn(input logic [2:0] k, input logic b);
        return ~((|k) & b);
    endfunction

endpackage

// File: rtl/oai31_bist_satcnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module oai31_bist_satcnt #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai31_bist.sv
// Walks an oai31 cell through all 16 input vectors, samples ZN after SETTLE
// cycles, counts mismatches and records which B->ZN arcs were verified.
module gf180mcu_fd_sc_mcu7t5v0__oai31_bist
    import oai31_bist_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             B,
    input  logic             ZN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [7:0]       ARC_MASK
);

    localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] VEC_LAST  = 4'(NUM_VEC - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_vec;
    logic [3:0] r_hold;
    logic [7:0] r_b0_ok;
    logic [7:0] r_arc;

    logic [2:0] w_k;
    logic       w_b;
    logic       w_exp;
    logic       w_match;
    logic       w_start;
    logic       w_sample;
    logic       w_busy;
    logic       w_done;

    assign w_k      = r_vec[3:1];
    assign w_b      = r_vec[0];
    assign w_exp    = exp_zn(w_k, w_b);
    // NOTE: === so an X or Z on ZN is a mismatch rather than a silent pass.
    assign w_match  = (ZN === w_exp);
    assign w_start  = START && ((r_state == IDLE) || (r_state == FIN));
    assign w_sample = (r_state == SAMPLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (START) w_next = RUN;
            RUN:     if (r_hold == HOLD_LAST) w_next = SAMPLE;
            SAMPLE:  w_next = (r_vec == VEC_LAST) ? FIN : RUN;
            FIN:     if (START) w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == RUN) || (r_state == SAMPLE);
        w_done = (r_state == FIN);
    end

    // Vector walk plus per-code B=0 match flags feeding the arc mask.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vec   <= '0;
            r_hold  <= '0;
            r_b0_ok <= '0;
            r_arc   <= '0;
        end else if (w_start) begin
            r_vec   <= '0;
            r_hold  <= '0;
            r_b0_ok <= '0;
            r_arc   <= '0;
        end else if (r_state == RUN) begin
            r_hold <= r_hold + 4'd1;
        end else if (w_sample) begin
            r_hold <= '0;
            if (r_vec != VEC_LAST) begin
                r_vec <= r_vec + 4'd1;
            end
            if (!w_b) begin
                r_b0_ok[w_k] <= w_match;
            end else if (w_match && r_b0_ok[w_k] && (w_exp != exp_zn(w_k, 1'b0))) begin
                r_arc[w_k] <= 1'b1;
            end
        end
    end

    oai31_bist_satcnt #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clr   (w_start),
        .i_inc   (w_sample && !w_match),
        .o_count (ERR_CNT)
    );

    assign A1       = w_busy & r_vec[3];
    assign A2       = w_busy & r_vec[2];
    assign A3       = w_busy & r_vec[1];
    assign B        = w_busy & r_vec[0];
    assign BUSY     = w_busy;
    assign DONE     = w_done;
    assign ARC_MASK = r_arc;
    assign PASS     = w_done && (ERR_CNT == '0) && (r_arc == ARC_EXPECT);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai31_bist.sv
// Bench for the oai31 BIST: three instances (SETTLE/CNT_W variants) each
// driving a table-based cell model, checked against spec-level expectations.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai31_bist;

    localparam logic [15:0] TBL_GOOD  = 16'h5557; // ~((A1|A2|A3)&B)
    localparam logic [15:0] TBL_STUCK = 16'hFFFF; // ZN stuck-at-1
    localparam logic [15:0] TBL_A1B   = 16'h55FF; // ~(A1&B)

    logic        CLK;
    logic        RST;
    logic [2:0]  start;
    logic [15:0] tbl [3];

    wire  [2:0]  a1, a2, a3, b, zn, busy, done, pass;
    wire  [7:0]  err0, err1, arc0, arc1, arc2;
    wire  [1:0]  err2;

    int n_cmp  = 0;
    int n_fail = 0;

    // Cell model: ZN looked up by vector index {A1,A2,A3,B}.
    assign zn[0] = tbl[0][{a1[0], a2[0], a3[0], b[0]}];
    assign zn[1] = tbl[1][{a1[1], a2[1], a3[1], b[1]}];
    assign zn[2] = tbl[2][{a1[2], a2[2], a3[2], b[2]}];

    gf180mcu_fd_sc_mcu7t5v0__oai31_bist #(.SETTLE(1), .CNT_W(8)) u_dut0 (
        .CLK(CLK), .RST(RST), .START(start[0]),
        .A1(a1[0]), .A2(a2[0]), .A3(a3[0]), .B(b[0]), .ZN(zn[0]),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
        .ERR_CNT(err0), .ARC_MASK(arc0)
    );

    gf180mcu_fd_sc_mcu7t5v0__oai31_bist #(.SETTLE(3), .CNT_W(8)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(start[1]),
        .A1(a1[1]), .A2(a2[1]), .A3(a3[1]), .B(b[1]), .ZN(zn[1]),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
        .ERR_CNT(err1), .ARC_MASK(arc1)
    );

    gf180mcu_fd_sc_mcu7t5v0__oai31_bist #(.SETTLE(3), .CNT_W(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .START(start[2]),
        .A1(a1[2]), .A2(a2[2]), .A3(a3[2]), .B(b[2]), .ZN(zn[2]),
        .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]),
        .ERR_CNT(err2), .ARC_MASK(arc2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [3:0] get_stim(input int idx);
        return {a1[idx], a2[idx], a3[idx], b[idx]};
    endfunction

    function automatic logic [7:0] get_err(input int idx);
        case (idx)
            0:       return err0;
            1:       return err1;
            default: return {6'b0, err2};
        endcase
    endfunction

    function automatic logic [7:0] get_arc(input int idx);
        case (idx)
            0:       return arc0;
            1:       return arc1;
            default: return arc2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input int idx, input string tag);
        check({tag, "_stim"}, 32'(get_stim(idx)), 32'h0);
        check({tag, "_busy"}, 32'(busy[idx]), 32'h0);
        check({tag, "_done"}, 32'(done[idx]), 32'h0);
        check({tag, "_pass"}, 32'(pass[idx]), 32'h0);
        check({tag, "_err"},  32'(get_err(idx)), 32'h0);
        check({tag, "_arc"},  32'(get_arc(idx)), 32'h0);
    endtask

    // Reference: count vectors whose ZN differs from the oai31 truth, then
    // credit arc k when both (k,B=0) and (k,B=1) match and B toggles ZN.
    task automatic model(input logic [15:0] t, input int cnt_max,
                         output logic [7:0] err, output logic [7:0] arc);
        int cnt = 0;
        arc = 8'h00;
        for (int v = 0; v < 16; v++) begin
            logic want;
            want = !(((v >> 1) != 0) && (v % 2 == 1));
            if (t[v] !== want) cnt++;
        end
        for (int k = 1; k < 8; k++) begin
            if (t[2*k] === 1'b1 && t[2*k+1] === 1'b0) arc[k] = 1'b1;
        end
        err = 8'((cnt > cnt_max) ? cnt_max : cnt);
    endtask

    task automatic run(input int idx, input int settle, input logic [15:0] t,
                       input bit hold, input logic [7:0] exp_err,
                       input logic [7:0] exp_arc, input string tag);
        int j;
        logic exp_pass;
        exp_pass = (exp_err == 8'h00) && (exp_arc == 8'hFE);
        tbl[idx] = t;
        @(negedge CLK);
        start[idx] = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) start[idx] = 1'b0;
        check({tag, "_t0_busy"}, 32'(busy[idx]), 32'h1);
        check({tag, "_t0_done"}, 32'(done[idx]), 32'h0);
        check({tag, "_t0_err"},  32'(get_err(idx)), 32'h0);
        check({tag, "_t0_arc"},  32'(get_arc(idx)), 32'h0);
        check({tag, "_t0_pass"}, 32'(pass[idx]), 32'h0);
        j = 0;
        while (!done[idx] && j < 2000) begin
            check({tag, "_stim"}, 32'(get_stim(idx)), 32'(j / (settle + 1)));
            @(posedge CLK);
            #1;
            j++;
        end
        start[idx] = 1'b0;
        check({tag, "_len"},  32'(j), 32'(16 * (settle + 1)));
        check({tag, "_busy"}, 32'(busy[idx]), 32'h0);
        check({tag, "_done"}, 32'(done[idx]), 32'h1);
        check({tag, "_err"},  32'(get_err(idx)), 32'(exp_err));
        check({tag, "_arc"},  32'(get_arc(idx)), 32'(exp_arc));
        check({tag, "_pass"}, 32'(pass[idx]), 32'(exp_pass));
        check({tag, "_idle_stim"}, 32'(get_stim(idx)), 32'h0);
        @(posedge CLK);
        #1;
        check({tag, "_hold_done"}, 32'(done[idx]), 32'h1);
        check({tag, "_hold_err"},  32'(get_err(idx)), 32'(exp_err));
    endtask

    initial begin
        logic [15:0] t;
        logic [7:0]  m_err, m_arc;

        RST   = 1'b1;
        start = 3'b000;
        for (int i = 0; i < 3; i++) tbl[i] = TBL_GOOD;

        // Reset applied before any clock edge.
        #2;
        for (int i = 0; i < 3; i++) check_idle(i, "por");
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) check_idle(i, "idle5");

        run(0, 1, TBL_GOOD,  1'b0, 8'd0, 8'hFE, "good_s1");
        run(1, 3, TBL_STUCK, 1'b0, 8'd7, 8'h00, "stuck_s3");
        run(2, 3, TBL_STUCK, 1'b0, 8'd3, 8'h00, "stuck_w2");
        run(0, 1, TBL_A1B,   1'b0, 8'd3, 8'hF0, "a1b_fin");

        // Abort a run at cycle 10 with an asynchronous reset pulse.
        tbl[0] = TBL_GOOD;
        @(negedge CLK);
        start[0] = 1'b1;
        @(posedge CLK);
        #1;
        start[0] = 1'b0;
        repeat (9) @(posedge CLK);
        #2;
        check("mid_busy_pre", 32'(busy[0]), 32'h1);
        RST = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check_idle(i, "midrst");
        @(negedge CLK);
        RST = 1'b0;

        run(0, 1, TBL_GOOD,  1'b0, 8'd0, 8'hFE, "after_rst");
        run(0, 1, TBL_GOOD,  1'b1, 8'd0, 8'hFE, "start_held");
        run(1, 3, TBL_STUCK, 1'b0, 8'd7, 8'h00, "stuck_again");
        run(1, 3, TBL_GOOD,  1'b0, 8'd0, 8'hFE, "fin_restart");

        for (int r = 0; r < 4; r++) begin
            t = 16'($urandom);
            model(t, 255, m_err, m_arc);
            run(0, 1, t, 1'b0, m_err, m_arc, $sformatf("rnd%0d_w8", r));
            model(t, 3, m_err, m_arc);
            run(2, 3, t, 1'b0, m_err, m_arc, $sformatf("rnd%0d_w2", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__oai31_bist.md
# gf180mcu_fd_sc_mcu7t5v0__oai31_bist

Self-test driver/checker for the oai31 cell family. It drives A1/A2/A3/B of a device-under-test oai31 instance through all 16 input vectors. It samples ZN after a programmable settle time, compares it to ~((A1|A2|A3)&B), counts mismatches and records which conditional B→ZN arcs were exercised correctly. It sits on the stimulus/response side of the cell interface, in cell-qualification benches and silicon test structures.

## Interface

Parameters:
- SETTLE, 1, cycles a vector is held before ZN is sampled; legal range 1..15.
- CNT_W, 8, width of the mismatch counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset; asynchronous, active-high.
- START  input  1  one-cycle request to begin a run.
- A1, A2, A3, B  output  1 each  stimulus to the DUT cell.
- ZN  input  1  DUT response.
- BUSY  output  1  run in progress.
- DONE  output  1  run complete; results valid.
- PASS  output  1  DONE && ERR_CNT==0 && ARC_MASK==8'hFE.
- ERR_CNT  output  CNT_W  saturating mismatch count.
- ARC_MASK  output  8  bit k set when the B→ZN arc under A-code k was verified.

## Operation

- Vector index v[3:0], 0..15. A-code k = v[3:1], mapped as A1=k[2], A2=k[1], A3=k[0]. B = v[0].
- Expected response: exp = ~((A1|A2|A3)&B).
- FSM states:
  - IDLE → RUN on START.
  - RUN: hold vector v for SETTLE cycles, then SAMPLE.
  - SAMPLE: compare ZN to exp. If v==15 go to FIN, else v++ and go to RUN.
  - FIN: DONE=1. START → RUN with results cleared.
- Mismatch:
  - ZN !== exp, so X or Z on ZN counts as a mismatch.
  - Each mismatch increments ERR_CNT, which saturates at 2^CNT_W−1.
- Arc tracking:
  - A per-code flag records that vector (k,B=0) matched.
  - On (k,B=1), if it matched, the flag is set, and exp differs from the (k,B=0) expectation, then ARC_MASK[k] is set.
  - ARC_MASK[0] is therefore always 0 (A=000 does not sensitize B; this is the ifnone arc). A good DUT yields 8'hFE.
- Outside RUN/SAMPLE, A1/A2/A3/B are driven to 0.
- START:
  - Ignored while BUSY.
  - In FIN, START clears ERR_CNT, ARC_MASK, DONE and PASS, then restarts at v=0.
- RST asserted at any time aborts immediately and returns all state and outputs to reset values.

## Timing

- Reset values: A1=A2=A3=B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, ARC_MASK=0, state IDLE.
- Start sequence:
  - START is sampled high at edge t0.
  - From t0, BUSY=1 and vector 0 is on the outputs.
- Per vector:
  - SETTLE+1 cycles, with vectors changing only on clock edges.
  - ZN is sampled at the edge ending the last cycle of the vector.
- Run length: 16·(SETTLE+1) cycles from START to the DONE rise.
- End of run:
  - On the edge that samples vector 15, BUSY falls and DONE rises.
  - ERR_CNT, ARC_MASK and PASS are final at the same edge.
- DONE and the results hold until the next START or RST.
- All outputs are registered; there are no combinational paths from ZN or START to outputs.

## Structure

- Package oai31_bist_pkg:
  - state enum {IDLE, RUN, SAMPLE, FIN}.
  - NUM_VEC=16.
  - ARC_EXPECT=8'hFE.
  - function exp_zn(k,b).
- One sub-module: oai31_bist_satcnt, a parameterized saturating counter (width, clear, inc).
- Everything else stays in the top module. The DUT cell is instantiated by the bench, not inside this block.

## Test plan

- Reset: assert RST with no clock → all outputs 0 immediately. Release, then 5 idle cycles → outputs unchanged, A/B=0.
- Good DUT (oai31_4 model), SETTLE=1: START pulse → BUSY high for 32 cycles, then DONE=1, ERR_CNT=0, ARC_MASK=8'hFE, PASS=1.
- ZN stuck-at-1, SETTLE=3: mismatches at the 7 vectors with k≠0, B=1 → DONE after 64 cycles, ERR_CNT=7, ARC_MASK=8'h00, PASS=0. Repeat with CNT_W=2 → ERR_CNT=3 (saturated).
- Faulty DUT ZN=~(A1&B): mismatches at codes 1, 2, 3 with B=1 → ERR_CNT=3, ARC_MASK=8'hF0, PASS=0.
- RST pulse at cycle 10 of a run → outputs return to reset values asynchronously. A following START runs all 16 vectors fresh → good-DUT result.
- START held during BUSY → ignored, run length unchanged. START in FIN → DONE falls at that edge, vector 0 driven, results cleared, full run repeats.
